// File: rtl/sprite_anim_renderer.sv
// Multi-frame sprite renderer: maps the scan position into a positioned, optionally mirrored
// sprite window, fetches palette indices from an external synchronous ROM, and animates frames on vsync.
module sprite_anim_renderer #(
   parameter  int SPRITE_W        = 50,
   parameter  int SPRITE_H        = 64,
   parameter  int FRAMES          = 4,
   parameter  int IDX_W           = 3,
   parameter  int TRANSPARENT_IDX = 0,
   parameter  int FRAME_PERIOD    = 6,
   localparam int ADDR_W          = $clog2(FRAMES * SPRITE_W * SPRITE_H),
   localparam int FRAME_W         = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
   input  logic               vga_clk,
   input  logic               reset_n,
   input  logic [9:0]         DrawX,
   input  logic [9:0]         DrawY,
   input  logic               blank,
   input  logic               frame_tick,
   input  logic [9:0]         sprite_x,
   input  logic [9:0]         sprite_y,
   input  logic               flip,
   input  logic               start,
   input  logic               loop,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [IDX_W-1:0]   rom_q,
   output logic [IDX_W-1:0]   pixel_idx,
   output logic               pixel_valid,
   output logic [FRAME_W-1:0] cur_frame,
   output logic               busy,
   output logic               anim_done
);

   localparam int TICK_W      = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
   localparam int FRAME_WORDS = SPRITE_W * SPRITE_H;

   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(FRAME_PERIOD - 1);
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [FRAME_W-1:0]  frame_q, frame_d;
   logic                anim_done_q, anim_done_d;

   // ---------------- animation FSM ----------------
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         tick_cnt_q  <= '0;
         frame_q     <= '0;
         anim_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         frame_q     <= frame_d;
         anim_done_q <= anim_done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      frame_d     = frame_q;
      anim_done_d = 1'b0;

      // A restart swallows any coincident tick.
      if (start) begin
         state_d    = ST_RUN;
         tick_cnt_d = '0;
         frame_d    = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               frame_d    = '0;
               tick_cnt_d = '0;
            end
            ST_RUN: begin
               if (frame_tick) begin
                  if (tick_cnt_q == TICK_LAST) begin
                     tick_cnt_d = '0;
                     if (frame_q != FRAME_LAST) begin
                        frame_d = frame_q + 1'b1;
                     end else if (loop) begin
                        frame_d = '0;
                     end else begin
                        state_d     = ST_DONE;
                        anim_done_d = 1'b1;
                     end
                  end else begin
                     tick_cnt_d = tick_cnt_q + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               frame_d = frame_q;
            end
            default: begin
               state_d    = ST_IDLE;
               tick_cnt_d = '0;
               frame_d    = '0;
            end
         endcase
      end
   end

   assign cur_frame = frame_q;
   assign busy      = (state_q == ST_RUN);
   assign anim_done = anim_done_q;

   // ---------------- pixel pipeline ----------------
   logic [10:0]       dx_w, dy_w, sx_w, sy_w, x_end, y_end;
   logic              in_box;
   logic [9:0]        lx_raw, lx, ly;
   logic [ADDR_W-1:0] addr_calc;

   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              v1_q, v1_d;
   logic              v2_q, v2_d;
   logic [IDX_W-1:0]  pix_idx_q, pix_idx_d;
   logic              pix_valid_q, pix_valid_d;

   // Window bounds are evaluated at 11 bits so a sprite near column 1023 does not wrap.
   always_comb begin
      dx_w   = {1'b0, DrawX};
      dy_w   = {1'b0, DrawY};
      sx_w   = {1'b0, sprite_x};
      sy_w   = {1'b0, sprite_y};
      x_end  = sx_w + 11'(SPRITE_W);
      y_end  = sy_w + 11'(SPRITE_H);
      in_box = (dx_w >= sx_w) && (dx_w < x_end) && (dy_w >= sy_w) && (dy_w < y_end);

      lx_raw = DrawX - sprite_x;
      ly     = DrawY - sprite_y;
      lx     = flip ? (10'(SPRITE_W - 1) - lx_raw) : lx_raw;

      addr_calc = ADDR_W'(int'(frame_q) * FRAME_WORDS)
                + ADDR_W'(int'(ly) * SPRITE_W)
                + ADDR_W'(lx);
   end

   always_comb begin
      rom_addr_d  = in_box ? addr_calc : rom_addr_q;
      v1_d        = in_box & blank;
      v2_d        = v1_q;
      pix_idx_d   = v2_q ? rom_q : '0;
      pix_valid_d = v2_q && (rom_q != IDX_W'(TRANSPARENT_IDX));
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_addr_q  <= '0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         pix_idx_q   <= '0;
         pix_valid_q <= 1'b0;
      end else begin
         rom_addr_q  <= rom_addr_d;
         v1_q        <= v1_d;
         v2_q        <= v2_d;
         pix_idx_q   <= pix_idx_d;
         pix_valid_q <= pix_valid_d;
      end
   end

   assign rom_addr    = rom_addr_q;
   assign pixel_idx   = pix_idx_q;
   assign pixel_valid = pix_valid_q;

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Self-checking bench: table-driven pixel vectors, hand-written animation/reset sequences,
// and a randomized run scored against a behavioural model of window, ROM and animation.
module tb_sprite_anim_renderer;

   localparam int SW     = 50;
   localparam int SH     = 64;
   localparam int NF     = 4;
   localparam int FP     = 2;
   localparam int ROM_SZ = NF * SW * SH;

   logic        vga_clk = 1'b0;
   logic        reset_n;
   logic [9:0]  DrawX, DrawY, sprite_x, sprite_y;
   logic        blank, frame_tick, flip, start, loop;
   logic [13:0] rom_addr;
   logic [2:0]  rom_q;
   logic [2:0]  pixel_idx;
   logic        pixel_valid;
   logic [1:0]  cur_frame;
   logic        busy, anim_done;

   logic [2:0]  rom_mem [0:ROM_SZ-1];

   int n_checks = 0;
   int n_pass   = 0;

   sprite_anim_renderer #(
      .SPRITE_W(SW), .SPRITE_H(SH), .FRAMES(NF), .IDX_W(3),
      .TRANSPARENT_IDX(0), .FRAME_PERIOD(FP)
   ) dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
      .blank(blank), .frame_tick(frame_tick), .sprite_x(sprite_x), .sprite_y(sprite_y),
      .flip(flip), .start(start), .loop(loop), .rom_addr(rom_addr), .rom_q(rom_q),
      .pixel_idx(pixel_idx), .pixel_valid(pixel_valid), .cur_frame(cur_frame),
      .busy(busy), .anim_done(anim_done)
   );

   always #5 vga_clk = ~vga_clk;

   // External synchronous ROM, one-cycle read latency.
   always @(posedge vga_clk) begin
      if (int'(rom_addr) < ROM_SZ) rom_q <= rom_mem[rom_addr];
      else                         rom_q <= 3'd0;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic cycle();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      DrawX = '0; DrawY = '0; sprite_x = '0; sprite_y = '0;
      blank = 1'b0; frame_tick = 1'b0; flip = 1'b0; start = 1'b0; loop = 1'b0;
      repeat (3) @(posedge vga_clk);
      @(negedge vga_clk);
      reset_n = 1'b1;
      repeat (3) cycle();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " rom_addr"}, int'(rom_addr), 0);
      check({tag, " pixel_idx"}, int'(pixel_idx), 0);
      check({tag, " pixel_valid"}, int'(pixel_valid), 0);
      check({tag, " cur_frame"}, int'(cur_frame), 0);
      check({tag, " busy"}, int'(busy), 0);
      check({tag, " anim_done"}, int'(anim_done), 0);
   endtask

   // ---------------- table vectors ----------------
   typedef struct {
      int dx, dy, sx, sy, fl, bl;
      int romv;      // value planted at addr, -1 = none
      int addr;      // expected rom_addr one cycle later (new or held)
      int idx, vld;  // expected pixel three cycles later
   } vec_t;

   vec_t vecs [11];

   // ---------------- behavioural model ----------------
   bit run_m, done_m;
   int n_m;

   function automatic int model_frame();
      if (run_m)  return n_m / FP;
      if (done_m) return NF - 1;
      return 0;
   endfunction

   typedef struct { int idx; int vld; } pix_t;
   pix_t pq[$];

   initial begin
      pix_t e, got;
      int   anim_exp;

      for (int i = 0; i < ROM_SZ; i++) rom_mem[i] = 3'd0;
      reset_n = 1'b0;
      DrawX = '0; DrawY = '0; sprite_x = '0; sprite_y = '0;
      blank = 1'b0; frame_tick = 1'b0; flip = 1'b0; start = 1'b0; loop = 1'b0;
      #2;
      check_all_zero("por");
      do_reset();

      // dx  dy   sx   sy  fl bl romv addr idx vld
      vecs[0]  = '{103, 205, 100, 200, 0, 1,  5,  253, 5, 1};
      vecs[1]  = '{103, 205, 100, 200, 1, 1,  6,  296, 6, 1};
      vecs[2]  = '{103, 205, 100, 200, 0, 1,  0,  253, 0, 0};
      vecs[3]  = '{150, 205, 100, 200, 0, 1, -1,  253, 0, 0};
      vecs[4]  = '{639, 205, 600, 200, 0, 1,  3,  289, 3, 1};
      vecs[5]  = '{639, 205, 600, 200, 0, 0,  3,  289, 0, 0};
      vecs[6]  = '{1020, 205, 1000, 200, 0, 1, 4, 270, 4, 1};
      vecs[7]  = '{100, 263, 100, 200, 0, 1,  7, 3150, 7, 1};
      vecs[8]  = '{100, 264, 100, 200, 0, 1, -1, 3150, 0, 0};
      vecs[9]  = '{99,  205, 100, 200, 1, 1, -1, 3150, 0, 0};
      vecs[10] = '{149, 205, 100, 200, 1, 1,  2,  250, 2, 1};

      foreach (vecs[k]) begin
         if (vecs[k].romv >= 0) rom_mem[vecs[k].addr] = 3'(vecs[k].romv);
         DrawX = 10'(vecs[k].dx); DrawY = 10'(vecs[k].dy);
         sprite_x = 10'(vecs[k].sx); sprite_y = 10'(vecs[k].sy);
         flip = vecs[k].fl[0]; blank = vecs[k].bl[0];
         cycle();
         check($sformatf("vec%0d rom_addr", k), int'(rom_addr), vecs[k].addr);
         cycle();
         cycle();
         check($sformatf("vec%0d pixel_idx", k), int'(pixel_idx), vecs[k].idx);
         check($sformatf("vec%0d pixel_valid", k), int'(pixel_valid), vecs[k].vld);
         $display("vec%0d x=%0d y=%0d flip=%0d blank=%0d -> addr=%0d idx=%0d valid=%0d",
                  k, vecs[k].dx, vecs[k].dy, vecs[k].fl, vecs[k].bl, rom_addr, pixel_idx, pixel_valid);
      end

      // ---------------- one-shot animation ----------------
      do_reset();
      loop = 1'b0;
      pulse_start();
      check("oneshot busy after start", int'(busy), 1);
      check("oneshot frame after start", int'(cur_frame), 0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("oneshot anim_done tick%0d", k), int'(anim_done), (k == 8) ? 1 : 0);
         check($sformatf("oneshot frame tick%0d", k), int'(cur_frame), (k == 8) ? 3 : k / 2);
         check($sformatf("oneshot busy tick%0d", k), int'(busy), (k == 8) ? 0 : 1);
         if (k == 2) begin
            DrawX = 10'd100; DrawY = 10'd200; sprite_x = 10'd100; sprite_y = 10'd200;
            flip = 1'b0; blank = 1'b1;
            cycle();
            check("frame1 base address", int'(rom_addr), 3200);
            blank = 1'b0;
         end
         cycle();
      end
      check("oneshot anim_done pulse ends", int'(anim_done), 0);
      check("oneshot frame held", int'(cur_frame), 3);
      $display("oneshot sequence: frame=%0d busy=%0d", cur_frame, busy);

      // ---------------- loop, then start coincident with tick ----------------
      loop = 1'b1;
      pulse_start();
      check("loop restart from DONE frame", int'(cur_frame), 0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         cycle();
      end
      check("loop wrap frame", int'(cur_frame), 0);
      check("loop wrap busy", int'(busy), 1);
      check("loop wrap no done", int'(anim_done), 0);
      repeat (4) begin tick(); cycle(); end
      check("loop reached frame2", int'(cur_frame), 2);
      start = 1'b1; frame_tick = 1'b1;
      cycle();
      start = 1'b0; frame_tick = 1'b0;
      check("start+tick frame", int'(cur_frame), 0);
      tick();
      check("start+tick first tick frame", int'(cur_frame), 0);
      tick();
      check("start+tick second tick frame", int'(cur_frame), 1);
      $display("loop/restart sequence: frame=%0d busy=%0d", cur_frame, busy);

      // ---------------- reset mid-animation ----------------
      do_reset();
      loop = 1'b0;
      pulse_start();
      repeat (4) begin tick(); cycle(); end
      check("pre-reset frame", int'(cur_frame), 2);
      rom_mem[2 * SW * SH + 253] = 3'd5;
      rom_mem[253] = 3'd5;
      DrawX = 10'd103; DrawY = 10'd205; sprite_x = 10'd100; sprite_y = 10'd200;
      flip = 1'b0; blank = 1'b1;
      repeat (3) cycle();
      check("pre-reset pixel_valid", int'(pixel_valid), 1);
      #2 reset_n = 1'b0;
      #1;
      check_all_zero("async reset");
      @(negedge vga_clk);
      reset_n = 1'b1;
      cycle();
      check("post-reset valid edge1", int'(pixel_valid), 0);
      cycle();
      check("post-reset valid edge2", int'(pixel_valid), 0);
      cycle();
      check("post-reset valid edge3", int'(pixel_valid), 1);
      check("post-reset idx edge3", int'(pixel_idx), 5);
      $display("reset sequence: idx=%0d valid=%0d frame=%0d", pixel_idx, pixel_valid, cur_frame);

      // ---------------- randomized run against model ----------------
      for (int i = 0; i < ROM_SZ; i++) rom_mem[i] = 3'($urandom_range(0, 7));
      do_reset();
      run_m = 0; done_m = 0; n_m = 0;
      pq.delete();
      pq.push_back('{0, 0});
      pq.push_back('{0, 0});
      for (int c = 0; c < 3000; c++) begin
         int sx, sy, dx, dy, fl, bl, fr, lx, ly, a;
         if (c % 64 == 0) begin
            sx = $urandom_range(0, 1023);
            sy = $urandom_range(0, 1023);
            sprite_x = 10'(sx); sprite_y = 10'(sy);
         end
         sx = int'(sprite_x); sy = int'(sprite_y);
         dx = (sx + $urandom_range(0, 60) + 1019) % 1024;
         dy = (sy + $urandom_range(0, 72) + 1019) % 1024;
         fl = int'($urandom_range(0, 1));
         bl = ($urandom_range(0, 7) != 0) ? 1 : 0;
         DrawX = 10'(dx); DrawY = 10'(dy); flip = fl[0]; blank = bl[0];
         frame_tick = ($urandom_range(0, 3) == 0);
         start      = ($urandom_range(0, 59) == 0);
         loop       = 1'($urandom_range(0, 1));

         e = '{0, 0};
         fr = model_frame();
         if (bl == 1 && dx >= sx && dx < sx + SW && dy >= sy && dy < sy + SH) begin
            lx = dx - sx;
            if (fl == 1) lx = SW - 1 - lx;
            ly = dy - sy;
            a = fr * SW * SH + ly * SW + lx;
            e.idx = int'(rom_mem[a]);
            e.vld = (e.idx != 0) ? 1 : 0;
         end

         cycle();

         anim_exp = 0;
         if (start) begin
            run_m = 1; done_m = 0; n_m = 0;
         end else if (run_m && frame_tick) begin
            n_m++;
            if (n_m == NF * FP) begin
               if (loop) n_m = 0;
               else begin run_m = 0; done_m = 1; anim_exp = 1; end
            end
         end
         check("rand cur_frame", int'(cur_frame), model_frame());
         check("rand busy", int'(busy), run_m ? 1 : 0);
         check("rand anim_done", int'(anim_done), anim_exp);

         pq.push_back(e);
         got = pq.pop_front();
         check("rand pixel_idx", int'(pixel_idx), got.idx);
         check("rand pixel_valid", int'(pixel_valid), got.vld);
      end
      $display("random run: 3000 cycles scored");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sprite_anim_renderer.md
Name: sprite_anim_renderer

Overview:
- Parametrised multi-frame sprite renderer for the VGA pipeline.
- Maps the current scan position (DrawX, DrawY) into a positioned, optionally mirrored sprite window.
- Issues addresses to an external synchronous sprite ROM and returns a palette index with a transparency-qualified valid flag.
- An internal animation FSM steps through FRAMES sprite frames on vertical-sync ticks, in one-shot or loop mode; it drives knight attack/walk cycles ahead of the palette/colour mux.

Parameters:
- SPRITE_W, 50, sprite width in pixels
- SPRITE_H, 64, sprite height in pixels
- FRAMES, 4, number of animation frames stored back-to-back in ROM
- IDX_W, 3, palette index width (ROM data width)
- TRANSPARENT_IDX, 0, palette index treated as transparent
- FRAME_PERIOD, 6, frame_tick pulses per animation frame (>=1)
- ADDR_W (localparam), $clog2(FRAMES*SPRITE_W*SPRITE_H), ROM address width; 14 at defaults

Ports:
- vga_clk  in  1  pixel clock; all logic on posedge
- reset_n  in  1  asynchronous active-low reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = active display region
- frame_tick  in  1  one-cycle pulse once per video frame (vsync)
- sprite_x  in  10  sprite top-left column
- sprite_y  in  10  sprite top-left row
- flip  in  1  1 = mirror horizontally
- start  in  1  one-cycle pulse: restart animation at frame 0
- loop  in  1  1 = wrap after last frame; 0 = one-shot
- rom_addr  out  ADDR_W  address to external ROM (ROM read latency 1 cycle)
- rom_q  in  IDX_W  ROM data, valid 1 cycle after rom_addr
- pixel_idx  out  IDX_W  palette index for the current pixel
- pixel_valid  out  1  1 = opaque sprite pixel inside window during blank
- cur_frame  out  $clog2(FRAMES)  frame being displayed
- busy  out  1  1 while in RUN
- anim_done  out  1  one-cycle pulse on one-shot completion

Behaviour:
- Reset (reset_n low, asynchronous):
  - All outputs 0.
  - FSM = IDLE; tick counter 0; pipeline valid bits 0.
- Pipeline (3-cycle fixed latency from DrawX/DrawY sample at edge N):
  - S1 (edge N+1):
    - in_box = DrawX >= sprite_x && DrawX < sprite_x+SPRITE_W && the same test on Y.
    - Compares use 11-bit sums, so no wrap at the 1023 boundary.
    - lx = DrawX - sprite_x, or SPRITE_W-1-lx when flip; ly = DrawY - sprite_y.
    - rom_addr <= cur_frame*SPRITE_W*SPRITE_H + ly*SPRITE_W + lx.
    - When !in_box, rom_addr holds its previous value.
    - Register v1 = in_box & blank.
  - S2 (edge N+2): v2 <= v1; rom_q is now valid for the S1 address.
  - S3 (edge N+3):
    - pixel_idx <= v2 ? rom_q : 0.
    - pixel_valid <= v2 && rom_q != TRANSPARENT_IDX.
  - flip, sprite_x and sprite_y are sampled at S1 only; mid-line changes affect subsequent pixels only.
- Animation FSM (states IDLE, RUN, DONE):
  - IDLE: cur_frame = 0, busy = 0. start -> RUN with tick_cnt = 0, cur_frame = 0.
  - RUN: busy = 1. Each frame_tick increments tick_cnt. When tick_cnt == FRAME_PERIOD-1 and frame_tick:
    - tick_cnt <= 0.
    - If cur_frame < FRAMES-1: cur_frame++.
    - Else if loop: cur_frame <= 0.
    - Else: -> DONE with anim_done = 1 for one cycle; cur_frame stays FRAMES-1.
  - DONE: holds last frame, busy = 0. start -> RUN from frame 0.
  - start has priority over a simultaneous frame_tick: restart wins, and that tick is not counted.
  - start during RUN restarts at frame 0 with tick_cnt = 0.
  - loop is sampled only at the last-frame boundary.
  - cur_frame changes only on frame_tick or start edges, so it is stable across a visible frame whenever start is vsync-aligned.
- Reset mid-animation returns to IDLE immediately; the pipeline flushes, so pixel_valid = 0 from the reset edge.

Test Plan:
- Reset: assert reset_n=0 mid-RUN, cur_frame=2 -> all outputs 0, FSM IDLE, pixel_valid 0 until 3 cycles after a valid in-box pixel.
- Address/latency: sprite_x=100, sprite_y=200, flip=0, frame 0, DrawX=103, DrawY=205, blank=1 -> rom_addr=253 one cycle later; ROM returning 5 -> pixel_idx=5, pixel_valid=1 at edge N+3.
- Flip and transparency, at the same position:
  - flip=1 -> rom_addr=5*50+46=296.
  - rom_q=0 -> pixel_valid=0, pixel_idx=0.
  - DrawX=150 (out of box) -> pixel_valid=0.
- Edge: sprite_x=600, DrawX=639 -> in box, lx=39; blank=0 -> pixel_valid=0.
- Animation, FRAME_PERIOD=2, FRAMES=4, loop=0:
  - start -> busy=1, frames 0,1,2,3 each held for 2 ticks.
  - After the 8th tick -> anim_done pulse, DONE, cur_frame=3; frame 1 address base = 3200.
- Loop and restart:
  - loop=1 -> after frame 3, cur_frame wraps to 0.
  - start coincident with frame_tick at frame 2 -> cur_frame=0, tick_cnt=0.
